// File: rtl/int_to_floating_point.sv
//------------------------------------------------------------------------------
// int_to_floating_point : iterative signed/unsigned 32/64-bit integer to
// IEEE-754 binary32 converter (one-bit-per-cycle normaliser, RNE rounding).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module int_to_floating_point (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        start_i,
    input  logic [1:0]  conv_i,
    input  logic [63:0] int_i,
    output logic [31:0] float_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        inexact_flag_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2
    } state_t;

    localparam logic [8:0] EXP_START = 9'd190;

    state_t      state_q;
    logic [63:0] mag_q;
    logic [8:0]  exp_q;
    logic        sign_q;
    logic [31:0] float_q;
    logic        busy_q;
    logic        done_q;
    logic        inexact_q;

    // Operand capture: source selection, sign and magnitude.
    logic [63:0] src_d;
    logic        sign_d;
    logic [63:0] mag_d;

    always_comb begin
        src_d  = 64'd0;
        sign_d = 1'b0;
        mag_d  = 64'd0;
        if (conv_i[1]) begin
            src_d = int_i;
        end else if (conv_i[0]) begin
            src_d = {32'd0, int_i[31:0]};
        end else begin
            src_d = {{32{int_i[31]}}, int_i[31:0]};
        end
        sign_d = ~conv_i[0] & src_d[63];
        // Negating 0x8000...0 yields itself, which read as unsigned is 2^63.
        mag_d  = sign_d ? (~src_d + 64'd1) : src_d;
    end

    // Round-to-nearest-even on the normalised magnitude.
    logic        mag_zero;
    logic [22:0] frac_raw;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] frac_sum;
    logic [7:0]  exp_rnd;

    always_comb begin
        mag_zero = (mag_q == 64'd0);
        frac_raw = mag_q[62:40];
        guard    = mag_q[39];
        sticky   = |mag_q[38:0];
        round_up = guard & (sticky | frac_raw[0]);
        frac_sum = {1'b0, frac_raw} + {23'd0, round_up};
        exp_rnd  = exp_q[7:0] + {7'd0, frac_sum[23]};
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= S_IDLE;
            mag_q     <= 64'd0;
            exp_q     <= 9'd0;
            sign_q    <= 1'b0;
            float_q   <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mag_q   <= mag_d;
                        sign_q  <= sign_d;
                        exp_q   <= EXP_START;
                        busy_q  <= 1'b1;
                        state_q <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (mag_zero || mag_q[63]) begin
                        state_q <= S_ROUND;
                    end else begin
                        mag_q <= {mag_q[62:0], 1'b0};
                        exp_q <= exp_q - 9'd1;
                    end
                end
                S_ROUND: begin
                    if (mag_zero) begin
                        float_q   <= 32'd0;
                        inexact_q <= 1'b0;
                    end else begin
                        // A carry out of the fraction leaves frac_sum[22:0] at zero.
                        float_q   <= {sign_q, exp_rnd, frac_sum[22:0]};
                        inexact_q <= guard | sticky;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign float_o        = float_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign inexact_flag_o = inexact_q;

endmodule

`default_nettype wire

// File: tb/tb_int_to_floating_point.sv
//------------------------------------------------------------------------------
// tb_int_to_floating_point : directed table-driven bench for the converter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_int_to_floating_point;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  conv;
    logic [63:0] int_v;
    logic [31:0] float_v;
    logic        busy;
    logic        done;
    logic        inexact;

    int checks = 0;
    int errors = 0;

    int_to_floating_point dut (
        .clk_i          (clk),
        .reset_ni       (reset_n),
        .start_i        (start),
        .conv_i         (conv),
        .int_i          (int_v),
        .float_o        (float_v),
        .busy_o         (busy),
        .done_o         (done),
        .inexact_flag_o (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  conv;
        logic [63:0] val;
        logic [31:0] exp_float;
        logic        exp_inexact;
        int          exp_lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Launch one conversion; an extra start pulse is driven before edge ign
    // (0 = none). Inputs are scrambled right after acceptance.
    task automatic run(input vec_t v, input int ign, input string name);
        int  lat;
        bit  seen;
        lat  = 0;
        seen = 0;
        @(negedge clk);
        conv  = v.conv;
        int_v = v.val;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        conv  = ~v.conv;
        int_v = ~v.val;
        check({name, " busy"}, {63'd0, busy}, 64'd1);
        for (int k = 1; k <= 100 && !seen; k++) begin
            start = (k == ign);
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                lat  = k;
                seen = 1;
            end
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL %s timeout: got no done, expected done within 100 cycles", name);
        end else begin
            check({name, " latency"}, 64'(lat), 64'(v.exp_lat));
            check({name, " float"}, {32'd0, float_v}, {32'd0, v.exp_float});
            check({name, " inexact"}, {63'd0, inexact}, {63'd0, v.exp_inexact});
            check({name, " busy at done"}, {63'd0, busy}, 64'd0);
            @(posedge clk);
            #1;
            check({name, " done pulse"}, {63'd0, done}, 64'd0);
            check({name, " idle after"}, {63'd0, busy}, 64'd0);
            check({name, " float held"}, {32'd0, float_v}, {32'd0, v.exp_float});
        end
    endtask

    initial begin
        vecs[0]  = '{2'b10, 64'hFFFFFFFFFFFFFFFF, 32'hBF800000, 1'b0, 65};
        vecs[1]  = '{2'b01, 64'h00000000FFFFFFFF, 32'h4F800000, 1'b1, 34};
        vecs[2]  = '{2'b10, 64'hFFFFFFFFFEFFFFFF, 32'hCB800000, 1'b1, 41};
        vecs[3]  = '{2'b10, 64'h8000000000000000, 32'hDF000000, 1'b0, 2};
        vecs[4]  = '{2'b00, 64'h0000000000000000, 32'h00000000, 1'b0, 2};
        vecs[5]  = '{2'b00, 64'hABCD0000FFFFFF85, 32'hC2F60000, 1'b0, 59};
        vecs[6]  = '{2'b11, 64'hFFFFFFFFFFFFFFFF, 32'h5F800000, 1'b1, 2};
        vecs[7]  = '{2'b01, 64'h0000000000000001, 32'h3F800000, 1'b0, 65};
        vecs[8]  = '{2'b00, 64'h000000007FFFFFFF, 32'h4F000000, 1'b1, 35};
        vecs[9]  = '{2'b00, 64'h0000000080000000, 32'hCF000000, 1'b0, 34};
        vecs[10] = '{2'b10, 64'h0000000000000003, 32'h40400000, 1'b0, 64};
        vecs[11] = '{2'b11, 64'h8000000000000001, 32'h5F000000, 1'b1, 2};
        vecs[12] = '{2'b10, 64'h0000000001000001, 32'h4B800000, 1'b1, 41};
        vecs[13] = '{2'b01, 64'hDEAD000000000010, 32'h41800000, 1'b0, 61};

        reset_n = 1'b0;
        start   = 1'b0;
        conv    = 2'b00;
        int_v   = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset float", {32'd0, float_v}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset inexact", {63'd0, inexact}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run(vecs[i], 0, $sformatf("vec%0d", i));
        end

        // Start pulses while busy, and coincident with done, must be ignored.
        run(vecs[0], 10, "ign_c10");
        run(vecs[1], 34, "ign_at_done");

        // Reset mid-conversion: abort, clear outputs, no done afterwards.
        begin
            bit saw_done;
            saw_done = 0;
            @(negedge clk);
            conv  = 2'b10;
            int_v = 64'hFFFFFFFFFFFFFFFF;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (20) @(posedge clk);
            #1;
            reset_n = 1'b0;
            #1;
            check("rst busy", {63'd0, busy}, 64'd0);
            check("rst float", {32'd0, float_v}, 64'd0);
            check("rst done", {63'd0, done}, 64'd0);
            check("rst inexact", {63'd0, inexact}, 64'd0);
            repeat (2) @(posedge clk);
            @(negedge clk);
            reset_n = 1'b1;
            for (int k = 0; k < 70; k++) begin
                @(posedge clk);
                #1;
                if (done || busy) saw_done = 1;
            end
            check("rst no pending", {63'd0, saw_done}, 64'd0);
        end

        run(vecs[5], 0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
